// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//   Decodes car passages on an entry lane and an exit lane, each watched by a
//   pair of photo sensors. Completed passages are serialised into one-cycle
//   enter/exit pulses for the occupancy counter. A passage that would overflow
//   or underflow the lot is discarded with a drop pulse.
//
//   Ports:
//     clk, Reset          clock, synchronous active-high reset
//     in_a, in_b          entry-lane sensors (a outer, b inner), 1 = blocked
//     out_a, out_b        exit-lane sensors (a inner, b outer), 1 = blocked
//     count[WIDTH-1:0]    current occupancy from the counter
//     enter, exit, drop   registered one-cycle service pulses (mutually exclusive)
//     full, empty         combinational occupancy status
//     gate_in_open        combinational entry-gate enable
//     seq_err[1:0]        registered one-cycle illegal-sequence pulse, bit0 entry, bit1 exit

// One lane decoder. done is high in the cycle whose sampled sensors
// complete a passage (B -> IDLE).
module parking_gate_lane (
    input  logic clk,
    input  logic Reset,
    input  logic a,
    input  logic b,
    output logic done,
    output logic seq_err
);
    typedef enum logic [2:0] {S_IDLE, S_A, S_AB, S_B, S_ERR} state_t;

    state_t state_q, state_d;
    logic   seq_err_q, seq_err_d;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: case ({a, b})
                2'b10:   state_d = S_A;
                2'b00:   state_d = S_IDLE;
                default: state_d = S_ERR;
            endcase
            S_A: case ({a, b})
                2'b11:   state_d = S_AB;
                2'b00:   state_d = S_IDLE;   // backed out, no request
                2'b10:   state_d = S_A;
                default: state_d = S_ERR;
            endcase
            S_AB: case ({a, b})
                2'b01:   state_d = S_B;
                2'b10:   state_d = S_A;
                2'b11:   state_d = S_AB;
                default: state_d = S_ERR;
            endcase
            S_B: case ({a, b})
                2'b00: begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
                2'b11:   state_d = S_AB;
                2'b01:   state_d = S_B;
                default: state_d = S_ERR;
            endcase
            S_ERR:   if ({a, b} == 2'b00) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Pulse only on the edge that enters ERR, not while parked there.
        seq_err_d = (state_d == S_ERR) && (state_q != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
endmodule

module parking_gate_controller #(
    parameter int CAPACITY = 25,
    parameter int WIDTH    = 5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             out_a,
    input  logic             out_b,
    input  logic [WIDTH-1:0] count,
    output logic             enter,
    output logic             exit,
    output logic             full,
    output logic             empty,
    output logic             gate_in_open,
    output logic [1:0]       seq_err,
    output logic             drop
);
    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

    // Lane index 0 = entry, 1 = exit.
    logic [1:0] sens_a, sens_b, done;
    assign sens_a = {out_a, in_a};
    assign sens_b = {out_b, in_b};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        parking_gate_lane u_lane (
            .clk     (clk),
            .Reset   (Reset),
            .a       (sens_a[g]),
            .b       (sens_b[g]),
            .done    (done[g]),
            .seq_err (seq_err[g])
        );
    end

    assign full         = (count >= CAP);
    assign empty        = (count == '0);
    assign gate_in_open = !full;

    logic [1:0] pend_q, pend_d;
    logic       ptr_q, ptr_d;          // 1 = exit lane has priority
    logic       enter_q, enter_d;
    logic       exit_q, exit_d;
    logic       drop_q, drop_d;
    logic       svc_in, svc_out;

    // A lane is never serviced in two consecutive cycles (a passage spans at
    // least four samples), so count has always caught up with a lane's own
    // previous pulse before that lane is serviced again.
    always_comb begin
        svc_in  = pend_q[0] && (!pend_q[1] || !ptr_q);
        svc_out = pend_q[1] && (!pend_q[0] ||  ptr_q);

        ptr_d   = (&pend_q) ? !ptr_q : ptr_q;

        enter_d = svc_in  && !full;
        exit_d  = svc_out && !empty;
        drop_d  = (svc_in && full) || (svc_out && empty);

        // Clear the serviced bit, then merge newly completed passages.
        pend_d  = (pend_q & ~{svc_out, svc_in}) | done;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pend_q  <= 2'b00;
            ptr_q   <= 1'b1;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            drop_q  <= drop_d;
        end
    end

    assign enter = enter_q;
    assign exit  = exit_q;
    assign drop  = drop_q;
endmodule
